// File: rtl/demux_regbank.sv
// 1-to-NCH demultiplexer with one registered valid/ready holding slot per channel.
// Words sent to a select with no channel behind it are counted in a saturating drop counter.
module demux_regbank #(
    parameter int unsigned W    = 8,
    parameter int unsigned NCH  = 4,
    parameter int unsigned SELW = 2,
    parameter int unsigned CNTW = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [W-1:0]      in_data,
    input  logic [SELW-1:0]   in_sel,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              flush,
    output logic [NCH*W-1:0]  out_data,
    output logic [NCH-1:0]    out_valid,
    input  logic [NCH-1:0]    out_ready,
    output logic [CNTW-1:0]   drop_count
);

    localparam int unsigned DW = NCH * W;

    logic [DW-1:0]   r_data;
    logic [NCH-1:0]  r_valid;
    logic [CNTW-1:0] r_drop;

    logic [NCH-1:0]  w_hit;
    logic [NCH-1:0]  w_push;
    logic [NCH-1:0]  w_pop;
    logic            w_in_range;
    logic            w_slot_free;
    logic            w_in_ready;
    logic            w_drop;

    // One-hot select decode; an all-zero w_hit marks an out-of-range select.
    always_comb begin
        w_hit = '0;
        for (int unsigned k = 0; k < NCH; k++) begin
            w_hit[k] = (32'(in_sel) == k);
        end
        w_in_range  = |w_hit;
        w_slot_free = |(w_hit & (~r_valid | out_ready));
        w_in_ready  = !flush && (!w_in_range || w_slot_free);
        w_push      = (in_valid && w_in_ready) ? w_hit : '0;
        w_pop       = r_valid & out_ready;
        w_drop      = in_valid && w_in_ready && !w_in_range;
    end

    // A push on a channel wins over its pop, so push-while-pop keeps the slot full.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_data  <= '0;
            r_valid <= '0;
            r_drop  <= '0;
        end else if (flush) begin
            r_data  <= '0;
            r_valid <= '0;
        end else begin
            for (int unsigned k = 0; k < NCH; k++) begin
                if (w_push[k]) begin
                    r_data[k*W +: W] <= in_data;
                    r_valid[k]       <= 1'b1;
                end else if (w_pop[k]) begin
                    r_valid[k] <= 1'b0;
                end
            end
            if (w_drop && (r_drop != '1)) begin
                r_drop <= r_drop + CNTW'(1);
            end
        end
    end

    assign in_ready   = w_in_ready;
    assign out_data   = r_data;
    assign out_valid  = r_valid;
    assign drop_count = r_drop;

endmodule

// File: doc/demux_regbank.md
Name: demux_regbank

Overview:
- Parametrised 1-to-NCH demultiplexer with one registered holding slot per output channel. Successor to the 1-to-4 combinational demux plus enable/reset flop.
- A W-bit word presented with a channel select is captured into that channel's register. It is then held with a valid flag until the channel consumer takes it.
- Sits between a single producer and NCH independent consumers. Uses valid/ready handshake on both sides.

Parameters:
- W, 8, data word width in bits (>=1)
- NCH, 4, number of output channels (>=2; need not be a power of two)
- SELW, 2, select width; must satisfy 2**SELW >= NCH
- CNTW, 8, width of the saturating drop counter

Ports:
- clk  input  1  clock; all state updates on posedge
- reset  input  1  synchronous, active-high reset
- in_data  input  W  word to route
- in_sel  input  SELW  destination channel index
- in_valid  input  1  producer offers in_data/in_sel this cycle
- in_ready  output  1  block accepts this cycle (combinational)
- flush  input  1  synchronous clear of all channel slots
- out_data  output  NCH*W  channel k data at bits [k*W +: W]
- out_valid  output  NCH  channel k slot holds a word
- out_ready  input  NCH  consumer k takes its word this cycle
- drop_count  output  CNTW  count of words accepted with in_sel >= NCH

Behaviour:
- Reset (reset=1 at posedge):
  - All out_valid=0, all out_data=0, drop_count=0.
  - Reset overrides flush, push and pop in the same cycle.
  - Reset mid-transfer discards held words without completing them.
- Channel k pop: when out_valid[k] && out_ready[k] at posedge, the word is consumed. out_valid[k] clears unless a push to k occurs the same cycle.
- in_ready, combinational:
  - flush=1 -> 0.
  - in_sel >= NCH -> 1.
  - Otherwise -> !out_valid[in_sel] || out_ready[in_sel]. Push-while-pop on a full slot is allowed.
- Push: when in_valid && in_ready && in_sel < NCH:
  - out_data[in_sel] <= in_data and out_valid[in_sel] <= 1 at posedge.
  - Latency from accept to out_valid visible is 1 cycle. There is no same-cycle pass-through.
- Simultaneous push and pop on the same channel: the new word replaces the old and out_valid stays 1. No bubble, no loss.
- Pushes to channel j and pops on channels k≠j proceed independently in the same cycle.
- Out-of-range select: when in_valid && in_sel >= NCH, the word is accepted (in_ready=1) and discarded.
  - drop_count increments by 1 per such word and saturates at 2**CNTW-1 (no wrap).
  - No channel state changes.
- Flush (flush=1, reset=0):
  - All out_valid <= 0 and all out_data <= 0 at posedge. Pops that cycle are ignored.
  - in_ready=0, so no push is accepted that cycle.
  - drop_count is unaffected.
- A channel holding a word keeps out_data stable while out_valid=1 && out_ready=0.
- out_data of a channel with out_valid=0 holds its last value (0 after reset/flush). Consumers ignore it.
- Producer rule: in_data/in_sel must be held stable while in_valid=1 && in_ready=0. The block does not check this.
- No other state exists. No combinational path exists from in_data to out_data.

Test Plan:
- Reset then idle -> out_valid=4'b0000, out_data=0, drop_count=0, in_ready=1 for every in_sel.
- Push 8'hA5 sel=2, out_ready=0 -> next cycle out_valid=4'b0100, out_data[23:16]=8'hA5. Second push sel=2 -> in_ready=0 and data stays 8'hA5. Assert out_ready[2] -> in_ready=1, new word 8'h3C lands with out_valid[2] staying 1.
- Four back-to-back pushes sel=0,1,2,3 (data 11,22,33,44), out_ready=0 -> out_valid=4'b1111 with correct slot contents. Then out_ready=4'b1010 for one cycle -> out_valid=4'b0101.
- NCH=3, SELW=2: push sel=3 ×5 -> in_ready=1 each cycle, drop_count=5, out_valid unchanged. CNTW=2 variant: 5 drops -> drop_count=3 (saturated).
- Slots 0 and 1 full; flush=1 with in_valid=1, sel=2 -> in_ready=0, next cycle out_valid=0 and out_data=0. drop_count is preserved.
- reset=1 and flush=1 together with push and pop pending -> all outputs at reset values next cycle, drop_count=0.
